// File: rtl/chunked_add_sequencer.sv
// Multi-cycle WIDTH-bit adder: drives an external CHUNK-bit combinational adder
// one slice per cycle, chaining the carry through carry_reg between slices.
module chunked_add_sequencer #(
   parameter int WIDTH = 64,
   parameter int CHUNK = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic [CHUNK-1:0] add_a,
   output logic [CHUNK-1:0] add_b,
   output logic             add_cin,
   input  logic [CHUNK-1:0] add_sum,
   input  logic             add_cout,
   output logic             busy
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                         state;
   logic [NCHUNK-1:0][CHUNK-1:0]   a_reg;
   logic [NCHUNK-1:0][CHUNK-1:0]   b_reg;
   logic [NCHUNK-1:0][CHUNK-1:0]   sum_reg;
   logic [IW-1:0]                  idx;
   logic                           carry_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         sum_reg   <= '0;
         idx       <= '0;
         carry_reg <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg     <= in_a;
                  b_reg     <= in_b;
                  carry_reg <= in_cin;
                  idx       <= '0;
                  state     <= RUN;
               end
            end
            RUN: begin
               // One slice per edge; the adder result settles within the cycle.
               sum_reg[idx] <= add_sum;
               carry_reg    <= add_cout;
               if (idx == LAST) state <= DONE;
               else             idx   <= idx + 1'b1;
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Adder operands are quiet outside RUN so the external cell sees no toggling.
   assign add_a   = (state == RUN) ? a_reg[idx] : '0;
   assign add_b   = (state == RUN) ? b_reg[idx] : '0;
   assign add_cin = (state == RUN) ? carry_reg  : 1'b0;

   assign in_ready  = (state == IDLE);
   assign busy      = (state != IDLE);
   assign out_valid = (state == DONE);
   assign out_sum   = out_valid ? sum_reg   : '0;
   assign out_cout  = out_valid ? carry_reg : 1'b0;

endmodule

// File: tb/tb_chunked_add_sequencer.sv
// Randomized + directed bench for chunked_add_sequencer against a plain-arithmetic model.
module tb_chunked_add_sequencer;

   localparam int W  = 64;
   localparam int C  = 16;
   localparam int NC = W / C;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, in_cin, out_ready;
   logic [W-1:0]  in_a, in_b;
   logic          in_ready, out_valid, out_cout, busy;
   logic [W-1:0]  out_sum;
   logic [C-1:0]  add_a, add_b, add_sum;
   logic          add_cin, add_cout;

   int passed = 0;
   int total  = 0;
   logic [NC-1:0]        last_cin_seq;
   logic [NC-1:0][C-1:0] last_a_seq;

   chunked_add_sequencer #(.WIDTH(W), .CHUNK(C)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_cout(out_cout),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_sum(add_sum), .add_cout(add_cout),
      .busy(busy)
   );

   // External 16-bit adder cell
   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + 17'(add_cin);

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [64:0] ref_add(input logic [63:0] a, b, input logic cin);
      return {1'b0, a} + {1'b0, b} + 65'(cin);
   endfunction

   // Carry entering slice k: carry out of the low k*C bits of the full add.
   function automatic logic carry_into(input logic [63:0] a, b, input logic cin, input int k);
      logic [64:0] mask, s;
      if (k == 0) return cin;
      mask = (65'd1 << (C * k)) - 65'd1;
      s = ({1'b0, a} & mask) + ({1'b0, b} & mask) + 65'(cin);
      return s[C * k];
   endfunction

   task automatic start_op(input logic [63:0] a, b, input logic cin);
      int n = 0;
      while (!in_ready && n < 50) begin tick(); n++; end
      chk("ready_wait", in_ready, 1);
      in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin;
      tick();
      in_valid = 1'b0;
   endtask

   // Accept, walk the RUN cycles checking the adder interface, then check the result.
   task automatic run_op(input logic [63:0] a, b, input logic cin);
      logic [64:0] r;
      logic [NC-1:0] ecs;
      start_op(a, b, cin);
      for (int k = 0; k < NC; k++) begin
         last_cin_seq[k] = add_cin;
         last_a_seq[k]   = add_a;
         ecs[k]          = carry_into(a, b, cin, k);
         chk("run_add_a", add_a, (a >> (C * k)) & 64'hFFFF);
         chk("run_add_b", add_b, (b >> (C * k)) & 64'hFFFF);
         chk("run_no_valid", out_valid, 0);
         chk("run_not_ready", in_ready, 0);
         tick();
      end
      r = ref_add(a, b, cin);
      chk("cin_seq", last_cin_seq, ecs);
      chk("done_valid", out_valid, 1);
      chk("done_sum", out_sum, r[63:0]);
      chk("done_cout", out_cout, r[64]);
      chk("done_busy", busy, 1);
      chk("done_add_cin", add_cin, 0);
   endtask

   task automatic release_out(input int d, input logic [63:0] es, input logic ec);
      for (int i = 0; i < d; i++) begin
         out_ready = 1'b0;
         tick();
         chk("hold_valid", out_valid, 1);
         chk("hold_sum", out_sum, es);
         chk("hold_cout", out_cout, ec);
      end
      out_ready = 1'b1;
      tick();
      chk("rel_valid", out_valid, 0);
      chk("rel_ready", in_ready, 1);
      out_ready = 1'b0;
   endtask

   initial begin
      logic [63:0] ra, rb;
      logic        rc;
      logic [64:0] r;
      rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
      #12;
      chk("rst_valid", out_valid, 0);
      chk("rst_sum", out_sum, 0);
      chk("rst_cout", out_cout, 0);
      chk("rst_add_a", add_a, 0);
      chk("rst_add_b", add_b, 0);
      chk("rst_add_cin", add_cin, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", in_ready, 1);
      #3 rst_n = 1'b1;
      tick();

      // 1: simple add, no carries
      run_op(64'd1, 64'd2, 1'b0);
      chk("s1_sum", out_sum, 64'h3);
      chk("s1_cin_seq", last_cin_seq, 4'b0000);
      release_out(0, 64'h3, 1'b0);

      // 2: full ripple carry
      run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
      chk("s2_sum", out_sum, 64'h0);
      chk("s2_cout", out_cout, 1);
      chk("s2_cin_seq", last_cin_seq, 4'b1111);
      release_out(1, 64'h0, 1'b1);

      // 3: carry crosses only the first slice boundary
      run_op(64'h0000_0000_0000_FFFF, 64'd1, 1'b0);
      chk("s3_sum", out_sum, 64'h0000_0000_0001_0000);
      chk("s3_cin_seq", last_cin_seq, 4'b0010);
      chk("s3_a0", last_a_seq[0], 16'hFFFF);
      chk("s3_a1", last_a_seq[1], 16'h0);

      // 4: backpressure with new operands pending
      in_valid = 1'b1; in_a = 64'h0000_0000_0000_00AA; in_b = 64'h0000_0000_0000_0055; in_cin = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("s4_valid", out_valid, 1);
         chk("s4_sum", out_sum, 64'h0000_0000_0001_0000);
         chk("s4_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("s4_idle_ready", in_ready, 1);
      chk("s4_idle_valid", out_valid, 0);
      tick();
      in_valid = 1'b0;
      chk("s4_accepted", busy, 1);
      repeat (NC) tick();
      chk("s4_new_valid", out_valid, 1);
      chk("s4_new_sum", out_sum, 64'h100);
      release_out(0, 64'h100, 1'b0);

      // 5: reset in the middle of RUN
      start_op(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0);
      tick(); tick();
      chk("s5_idx2_a", add_a, 16'h5678);
      rst_n = 1'b0;
      #1;
      chk("s5_rst_valid", out_valid, 0);
      chk("s5_rst_busy", busy, 0);
      chk("s5_rst_add_a", add_a, 0);
      chk("s5_rst_add_b", add_b, 0);
      chk("s5_rst_add_cin", add_cin, 0);
      #2 rst_n = 1'b1;
      tick();
      chk("s5_post_ready", in_ready, 1);
      run_op(64'd5, 64'd7, 1'b0);
      chk("s5_sum", out_sum, 64'd12);
      release_out(0, 64'd12, 1'b0);

      // 6: back-to-back issue with out_ready tied high
      out_ready = 1'b1;
      in_valid = 1'b1; in_a = 64'h8000_0000_0000_0000; in_b = 64'h8000_0000_0000_0000; in_cin = 1'b0;
      tick();
      chk("s6_acc1", busy, 1);
      in_a = 64'd3; in_b = 64'd4;
      for (int n = 1; n <= 6; n++) begin
         tick();
         if (n < 4) chk("s6_run_valid", out_valid, 0);
         if (n == 4) begin
            chk("s6_v1", out_valid, 1);
            chk("s6_sum1", out_sum, 64'h0);
            chk("s6_cout1", out_cout, 1);
         end
         if (n == 5) begin
            chk("s6_idle_ready", in_ready, 1);
            chk("s6_idle_busy", busy, 0);
         end
         if (n == 6) chk("s6_acc2", busy, 1);
      end
      in_valid = 1'b0;
      repeat (NC) tick();
      chk("s6_v2", out_valid, 1);
      chk("s6_sum2", out_sum, 64'd7);
      chk("s6_cout2", out_cout, 0);
      tick();
      out_ready = 1'b0;
      chk("s6_end_ready", in_ready, 1);

      // Randomized operands with random backpressure
      for (int t = 0; t < 12; t++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         rc = 1'($urandom_range(0, 1));
         if (t == 0) rb = ~ra;
         r = ref_add(ra, rb, rc);
         run_op(ra, rb, rc);
         release_out(int'($urandom_range(0, 3)), r[63:0], r[64]);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
